// File: rtl/ysyx_220053_imem_pkg.sv
// rtl/ysyx_220053_imem_pkg.sv - shared types, constants and helpers for the imem responder
package ysyx_220053_imem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } imem_state_t;

  localparam logic [63:0] IMEM_BASE  = 64'h0000_0000_8000_0000;
  localparam int          IMEM_DEPTH = 4096;

  // Picks the 32-bit instruction out of a 64-bit memory word by address bit 2.
  function automatic logic [31:0] sel_instr(input logic [63:0] word, input logic hi);
    return hi ? word[63:32] : word[31:0];
  endfunction

endpackage

// File: rtl/ysyx_220053_imem_array.sv
// rtl/ysyx_220053_imem_array.sv - 64-bit word store, synchronous loader write, combinational read
module ysyx_220053_imem_array #(
  parameter int DEPTH = 4096,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] widx,
  input  logic [63:0]   wdata,
  input  logic [AW-1:0] ridx,
  output logic [63:0]   rdata
);

  logic [63:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[widx] <= wdata;
    end
  end

  // A write in the same cycle is only visible after the edge, so readers see old data.
  assign rdata = mem[ridx];

endmodule

// File: rtl/ysyx_220053_imem_responder.sv
// rtl/ysyx_220053_imem_responder.sv - fetch-side imem responder; IMEM_RAND_LAT_EN adds LFSR latency jitter
module ysyx_220053_imem_responder
  import ysyx_220053_imem_pkg::*;
#(
  parameter logic [63:0] BASE    = IMEM_BASE,
  parameter int          DEPTH   = IMEM_DEPTH,
  parameter int          LATENCY = 2,
  localparam int         AW      = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [63:0]   req_addr,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic [31:0]   resp_instr,
  output logic          resp_err,
  input  logic          flush,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_idx,
  input  logic [63:0]   ld_data
);

  localparam int          CW    = $clog2(LATENCY + 4);
  localparam logic [63:0] LIMIT = BASE + (64'(DEPTH) << 3);

  imem_state_t   state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [CW-1:0] lat_m1;
  logic [63:0]   offset;
  logic [AW-1:0] rd_idx;
  logic [63:0]   rd_word;
  logic          addr_err;
  logic          accept;

  assign offset   = req_addr - BASE;
  assign rd_idx   = AW'(offset >> 3);
  assign addr_err = (req_addr[1:0] != 2'b00) || (req_addr < BASE) || (req_addr >= LIMIT);

  ysyx_220053_imem_array #(.DEPTH(DEPTH)) u_array (
    .clk   (clk),
    .we    (ld_en),
    .widx  (ld_idx),
    .wdata (ld_data),
    .ridx  (rd_idx),
    .rdata (rd_word)
  );

`ifdef IMEM_RAND_LAT_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr <= 16'hACE1;
    end else begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  assign lat_m1 = CW'(LATENCY - 1) + CW'(lfsr[1:0]);
`else
  assign lat_m1 = CW'(LATENCY - 1);
`endif

  // Gated by rst so the port reads low for as long as reset is held.
  assign req_ready  = rst && (state == IDLE) && !flush;
  assign resp_valid = (state == RESP);
  assign accept     = req_valid && req_ready;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          cnt_nxt   = lat_m1;
          state_nxt = (lat_m1 == '0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_nxt = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          state_nxt = RESP;
        end
        if (flush) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      end
      RESP: begin
        // Flush wins over a same-cycle handshake; both leave for IDLE anyway.
        if (flush || resp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      resp_instr <= '0;
      resp_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        resp_instr <= addr_err ? 32'd0 : sel_instr(rd_word, req_addr[2]);
        resp_err   <= addr_err;
      end
    end
  end

endmodule

// File: doc/ysyx_220053_imem_responder.md
Name: ysyx_220053_imem_responder

Overview:
Instruction-memory responder serving the fetch side of the core. It accepts one fetch request at a time, waits a configurable latency, and returns the selected 32-bit instruction word. It holds that response until the fetch stage consumes it or a redirect flushes it. The backing store is a 64-bit-word array preloaded through a loader write port, and the block sits between the IFU request interface and the simulated instruction memory.

Parameters:
BASE, 64'h80000000, byte address of word 0
DEPTH, 4096, number of 64-bit words (power of two)
LATENCY, 2, cycles from request accept to resp_valid (≥1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
req_valid  in  1  fetch request valid
req_ready  out  1  responder can accept a request
req_addr  in  64  instruction byte address (pc)
resp_valid  out  1  response valid
resp_ready  in  1  fetch stage accepts response
resp_instr  out  32  instruction: addr[2]=0 → word[31:0], 1 → word[63:32]
resp_err  out  1  misaligned or out-of-range request
flush  in  1  redirect: drop any pending or held response
ld_en  in  1  loader write enable
ld_idx  in  log2(DEPTH)  loader word index
ld_data  in  64  loader write data

Behaviour:
- Reset (rst=0, async): state=IDLE, counter=0, req_ready=0, resp_valid=0, resp_instr=0, resp_err=0. Array contents are not reset.
- States:
  - IDLE: req_ready=1 unless flush=1.
  - WAIT: counter counts down.
  - RESP: resp_valid=1.
- Accept: in IDLE with req_valid&req_ready at edge T.
  - Capture addr bit 2, the err flag, and the array word read at T.
  - A same-cycle ld_en to the same index returns the OLD data.
  - Load counter=LATENCY-1. Go to WAIT, or to RESP directly if LATENCY=1.
- WAIT: decrement each cycle; at 0 go to RESP. resp_valid first high in cycle T+LATENCY.
- RESP: resp_instr/resp_err stay stable while resp_valid=1 and resp_ready=0.
  - On resp_valid&resp_ready: return to IDLE. req_ready=1 the next cycle; no back-to-back accept in the same cycle as the response.
- Error rules:
  - err=1 if addr[1:0]!=0, addr<BASE, or addr>=BASE+8*DEPTH.
  - On err, resp_instr=0. An error still completes a normal handshake after LATENCY.
- Index: (addr-BASE)[log2(DEPTH)+2:3], 64-bit subtraction, upper bits ignored after the range check.
- flush=1 in WAIT or RESP: go to IDLE next cycle and set resp_valid=0 next cycle.
  - Flush has priority over a same-cycle resp_ready; that transfer does not count.
- flush in IDLE: no accept that cycle.
- ld_en: writes ld_data at ld_idx every cycle it is high, independent of state.
- Mid-operation reset: immediate return to the reset values; the outstanding request is lost.

Optional Feature:
IMEM_RAND_LAT_EN
- Defined: a 16-bit LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1 at reset) advances every cycle. At accept, the effective latency = LATENCY + LFSR[1:0] (range LATENCY..LATENCY+3), used to stress IFU stall handling.
- Undefined: fixed LATENCY, no LFSR logic.

Decomposition:
Package ysyx_220053_imem_pkg holds:
- state enum IDLE/WAIT/RESP (2 bits)
- IMEM_BASE and IMEM_DEPTH constants
- an instr-select helper function

One sub-module is natural: ysyx_220053_imem_array, a synchronous-write, combinational-read 64-bit memory with loader port.

Test Plan:
- Load idx0=64'h00100093_00000513, req 0x80000000 then 0x80000004, resp_ready=1 → resp_instr 0x00000513 then 0x00100093, each resp_valid exactly LATENCY cycles after its accept.
- Response held with resp_ready=0 for 5 cycles → resp_valid and resp_instr stable, req_ready=0; handshake on cycle 6 → req_ready=1 next cycle.
- req 0x80000002 → resp_err=1, resp_instr=0. req 0x7FFFFFFC and 0x80000000+8*DEPTH → resp_err=1.
- flush one cycle after accept (LATENCY=2) → no resp_valid ever for that request. flush with resp_valid&resp_ready → resp_valid low next cycle, IDLE.
- ld_en to idx 3 in the same cycle as accept of 0x80000018 → old word returned; the next request to the same address returns the new word.
- rst low mid-WAIT → resp_valid=0 and req_ready=0 immediately. After release, the first accept behaves normally.
